// File: rtl/vga_text_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_text_pkg
//  Description : Shared constants, control codes, FSM encoding and the tile
//                address helper for the VGA text buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_text_pkg;

    localparam int COLS      = 80;   // 640 / 8
    localparam int ROWS      = 30;   // 480 / 16
    localparam int CW        = 7;    // character code width
    localparam int ADDR_W    = 12;
    localparam int NUM_TILES = COLS * ROWS;

    localparam logic [CW-1:0] CH_BS    = 7'h08;
    localparam logic [CW-1:0] CH_LF    = 7'h0A;
    localparam logic [CW-1:0] CH_FF    = 7'h0C;
    localparam logic [CW-1:0] CH_CR    = 7'h0D;
    localparam logic [CW-1:0] CH_SPACE = 7'h20;
    localparam logic [CW-1:0] CH_TILDE = 7'h7E;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_TILES - 1);
    localparam logic [6:0]        COL_LAST  = 7'(COLS - 1);
    localparam logic [4:0]        ROW_LAST  = 5'(ROWS - 1);

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    // row*80 + col, with the multiply done as (r<<6)+(r<<4)
    function automatic logic [ADDR_W-1:0] tile_addr(input logic [ADDR_W-1:0] row,
                                                    input logic [ADDR_W-1:0] col);
        return (row << 6) + (row << 4) + col;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_text_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_text_buffer_if
//  Description : Character write handshake between a producer and the text
//                buffer.
//                wr_valid : producer presents wr_char
//                wr_ready : buffer accepts a character this cycle
//                wr_char  : ASCII code to write or interpret
//  Revision    : 1.0 - initial release
// ============================================================================
interface vga_text_buffer_if;
    import vga_text_pkg::*;

    logic          wr_valid;
    logic          wr_ready;
    logic [CW-1:0] wr_char;

    modport master (output wr_valid, output wr_char, input  wr_ready);
    modport slave  (input  wr_valid, input  wr_char, output wr_ready);
endinterface
`default_nettype wire

// File: rtl/text_ram.sv
`default_nettype none
// ============================================================================
//  Module      : text_ram
//  Description : Simple dual-port character RAM, one synchronous write port
//                and one registered read port. No reset, block-RAM friendly.
//                Read of an address written in the same cycle returns the old
//                contents.
//  Ports       : clk, we/waddr/wdata (write), raddr/rdata (read, 1 cycle)
//  Revision    : 1.0 - initial release
// ============================================================================
module text_ram #(
    parameter int DEPTH = 2400,
    parameter int WIDTH = 7,
    parameter int AW    = 12
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        rdata <= mem[raddr];
    end

endmodule
`default_nettype wire

// File: rtl/vga_text_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : vga_text_buffer
//  Description : 80x30 character buffer for the VGA text path. Accepts codes
//                over a valid/ready handshake, tracks a write cursor, handles
//                CR/LF/BS/FF, and returns the code of the tile under the beam
//                one cycle after pix_x/pix_y.
//  Ports       : clk, reset (async, active low), wr_bus (slave handshake),
//                pix_x/pix_y (beam position), char_code (registered tile
//                code), cursor_col/cursor_row, busy (clear in progress)
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_text_buffer
    import vga_text_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    vga_text_buffer_if.slave    wr_bus,
    input  logic [9:0]          pix_x,
    input  logic [9:0]          pix_y,
    output logic [CW-1:0]       char_code,
    output logic [6:0]          cursor_col,
    output logic [4:0]          cursor_row,
    output logic                busy
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic [6:0]        col_q, col_d;
    logic [4:0]        row_q, row_d;
    logic              wr_ready_q, wr_ready_d;
    logic              busy_q, busy_d;
    logic              blank_q, blank_d;

    logic              accept;
    logic [4:0]        row_inc;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr, ram_raddr;
    logic [CW-1:0]     ram_wdata, ram_rdata;

    assign accept  = wr_bus.wr_valid && wr_ready_q;
    assign row_inc = (row_q == ROW_LAST) ? 5'd0 : row_q + 5'd1;

    // Write side: clear sweep, printable writes, backspace erase
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        col_d      = col_q;
        row_d      = row_q;
        ram_we     = 1'b0;
        ram_waddr  = clr_addr_q;
        ram_wdata  = CH_SPACE;

        case (state_q)
            CLEAR: begin
                ram_we = 1'b1;
                if (clr_addr_q == LAST_ADDR) begin
                    state_d = IDLE;
                end else begin
                    clr_addr_d = clr_addr_q + 12'd1;
                end
            end
            IDLE: begin
                if (accept) begin
                    if (wr_bus.wr_char >= CH_SPACE && wr_bus.wr_char <= CH_TILDE) begin
                        ram_we    = 1'b1;
                        ram_waddr = tile_addr({7'd0, row_q}, {5'd0, col_q});
                        ram_wdata = wr_bus.wr_char;
                        if (col_q == COL_LAST) begin
                            col_d = 7'd0;
                            row_d = row_inc;
                        end else begin
                            col_d = col_q + 7'd1;
                        end
                    end else begin
                        case (wr_bus.wr_char)
                            CH_CR: col_d = 7'd0;
                            CH_LF: row_d = row_inc;
                            CH_BS: begin
                                if (col_q != 7'd0) begin
                                    col_d     = col_q - 7'd1;
                                    ram_we    = 1'b1;
                                    ram_waddr = tile_addr({7'd0, row_q}, {5'd0, col_q - 7'd1});
                                end
                            end
                            CH_FF: begin
                                col_d      = 7'd0;
                                row_d      = 5'd0;
                                clr_addr_d = '0;
                                state_d    = CLEAR;
                            end
                            default: ;  // consumed and ignored
                        endcase
                    end
                end
            end
            default: state_d = CLEAR;
        endcase

        // Status flags follow the next state so they are registered with it
        wr_ready_d = (state_d == IDLE);
        busy_d     = (state_d == CLEAR);
    end

    // Read side: out-of-screen coordinates are steered to a safe address
    // and masked to a space after the RAM read
    always_comb begin
        blank_d   = (pix_x >= 10'd640) || (pix_y >= 10'd480);
        ram_raddr = blank_d ? '0 : tile_addr({6'd0, pix_y[9:4]}, {5'd0, pix_x[9:3]});
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
            col_q      <= 7'd0;
            row_q      <= 5'd0;
            wr_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            blank_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            col_q      <= col_d;
            row_q      <= row_d;
            wr_ready_q <= wr_ready_d;
            busy_q     <= busy_d;
            blank_q    <= blank_d;
        end
    end

    text_ram #(
        .DEPTH (NUM_TILES),
        .WIDTH (CW),
        .AW    (ADDR_W)
    ) u_text_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    assign wr_bus.wr_ready = wr_ready_q;
    assign busy            = busy_q;
    assign cursor_col      = col_q;
    assign cursor_row      = row_q;
    // blank_q resets to 1, so char_code is a space while the RAM is unknown
    assign char_code       = blank_q ? CH_SPACE : ram_rdata;

endmodule
`default_nettype wire

// File: tb/tb_vga_text_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_text_buffer
//  Description : Self-checking bench for vga_text_buffer. A screen-level
//                model (array of tiles, cursor, clear countdown) predicts
//                every output after each clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_text_buffer;
    import vga_text_pkg::*;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic [9:0]    pix_x = '0;
    logic [9:0]    pix_y = '0;
    logic [CW-1:0] char_code;
    logic [6:0]    cursor_col;
    logic [4:0]    cursor_row;
    logic          busy;

    vga_text_buffer_if bus ();

    vga_text_buffer dut (
        .clk        (clk),
        .reset      (reset),
        .wr_bus     (bus),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .char_code  (char_code),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Reference model state
    int m_mem [2400];
    int m_col;
    int m_row;
    int m_clear_left;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_col        = 0;
        m_row        = 0;
        m_clear_left = 2400;
        for (int i = 0; i < 2400; i++) m_mem[i] = 32;
    endtask

    task automatic model_char(input int ch);
        if (ch >= 32 && ch <= 126) begin
            m_mem[m_row * 80 + m_col] = ch;
            if (m_col == 79) begin
                m_col = 0;
                m_row = (m_row + 1) % 30;
            end else begin
                m_col++;
            end
        end else if (ch == 13) begin
            m_col = 0;
        end else if (ch == 10) begin
            m_row = (m_row + 1) % 30;
        end else if (ch == 8) begin
            if (m_col > 0) begin
                m_col--;
                m_mem[m_row * 80 + m_col] = 32;
            end
        end else if (ch == 12) begin
            model_reset();
        end
    endtask

    task automatic check_reset_values();
        check_eq("rst_wr_ready", bus.wr_ready, 0);
        check_eq("rst_busy", busy, 1);
        check_eq("rst_char_code", char_code, 32'h20);
        check_eq("rst_cursor_col", cursor_col, 0);
        check_eq("rst_cursor_row", cursor_row, 0);
    endtask

    // One clock: drive inputs, advance the model at the edge, check after it.
    task automatic tick(input bit v, input int ch, input int px, input int py);
        bit known;
        int exp_code;
        bus.wr_valid = v;
        bus.wr_char  = 7'(ch);
        pix_x        = 10'(px);
        pix_y        = 10'(py);
        @(posedge clk);
        // Reads taken while a clear is running may see old text or spaces
        known    = (m_clear_left == 0);
        exp_code = (px >= 640 || py >= 480) ? 32 : m_mem[(py / 16) * 80 + px / 8];
        if (m_clear_left > 0) m_clear_left--;
        else if (v) model_char(ch);
        #1;
        check_eq("wr_ready", bus.wr_ready, (m_clear_left == 0));
        check_eq("busy", busy, (m_clear_left != 0));
        check_eq("cursor_col", cursor_col, m_col);
        check_eq("cursor_row", cursor_row, m_row);
        if (known) check_eq("char_code", char_code, exp_code);
        @(negedge clk);
    endtask

    function automatic int rand_char();
        int r;
        int c;
        r = int'($urandom_range(0, 9));
        if (r < 7) return int'($urandom_range(32, 126));
        if (r == 7) begin
            c = int'($urandom_range(0, 2));
            return (c == 0) ? 13 : (c == 1) ? 10 : 8;
        end
        c = int'($urandom_range(0, 127));
        return (c == 12) ? 0 : c;
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wr_valid = 1'b0;
        bus.wr_char  = '0;
        model_reset();

        // Reset values
        repeat (3) @(posedge clk);
        #1 check_reset_values();
        @(negedge clk);
        reset = 1'b1;

        // Power-up clear: ready low for 2400 edges, then high
        repeat (2402) tick(0, 0, 0, 0);

        // Every tile reads back a space
        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 80; c++)
                tick(0, 0, c * 8 + int'($urandom_range(0, 7)), r * 16 + int'($urandom_range(0, 15)));

        // "AB" back-to-back, read tile (1,0)
        tick(1, 'h41, 0, 0);
        tick(1, 'h42, 0, 0);
        tick(0, 0, 8, 0);

        // 81 printable characters from (0,0)
        tick(1, 13, 0, 0);
        for (int i = 0; i < 81; i++) tick(1, int'($urandom_range(32, 126)), 0, 0);
        tick(0, 0, 0, 16);
        tick(0, 0, 7, 31);

        // LF wrap from row 29, BS at column 0, 'X' then BS
        tick(1, 13, 0, 0);
        for (int i = 0; i < 28; i++) tick(1, 10, 0, 0);
        tick(1, 10, 0, 0);
        tick(1, 8, 0, 0);
        tick(1, 'h58, 0, 0);
        tick(0, 0, 0, 0);
        tick(1, 8, 0, 0);
        tick(0, 0, 3, 5);

        // Blanking regardless of RAM contents, plus screen-edge tiles
        tick(1, 'h41, 0, 0);
        tick(0, 0, 700, 10);
        tick(0, 0, 5, 480);
        tick(0, 0, 639, 479);
        tick(0, 0, 0, 0);

        // Write and read the same tile in one cycle: old contents returned
        tick(1, 13, 0, 0);
        tick(1, 'h55, 0, m_row * 16);
        tick(0, 0, 0, m_row * 16);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            int py;
            py = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 524));
            tick($urandom_range(0, 3) != 0, rand_char(), int'($urandom_range(0, 799)), py);
        end

        // FF mid-text, then reset during the clear
        tick(1, 12, 0, 0);
        repeat (999) tick(0, 0, 0, 0);
        reset = 1'b0;
        #1 check_reset_values();
        model_reset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (2402) tick(0, 0, 0, 0);

        // Random writes, then a full FF clear with writes pending during it
        for (int i = 0; i < 300; i++)
            tick($urandom_range(0, 3) != 0, rand_char(), int'($urandom_range(0, 799)), int'($urandom_range(0, 63)));
        tick(1, 12, 0, 0);
        for (int i = 0; i < 2402; i++)
            tick($urandom_range(0, 1) == 1, rand_char(), 0, 0);
        for (int i = 0; i < 300; i++)
            tick($urandom_range(0, 3) != 0, rand_char(), int'($urandom_range(0, 799)), int'($urandom_range(0, 63)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
